sync_arb_frontend: RTL
======================

SYNC_ARB_FRONTEND -- requirements
Module: sync_arb_frontend

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of the client payload and hs_data.
REQ-002 SHALL have parameter SYNC_STAGES, default 2 (legal 2..4), meaning number of flops in the hs_ack synchronizer.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, meaning the watchdog limit in clk cycles, used only when ARB_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port cli0_valid  input  1  meaning client 0 has a word to send.
REQ-007 SHALL have port cli0_data  input  DATA_W  meaning client 0 payload.
REQ-008 SHALL have port cli0_ready  output  1  meaning client 0 word is accepted this cycle.
REQ-009 SHALL have ports cli1_valid, cli1_data and cli1_ready with the same directions, widths and meanings as REQ-006..REQ-008, for client 1.
REQ-010 SHALL have port hs_req  output  1  meaning four-phase request to the downstream locker control (its req_in).
REQ-011 SHALL have port hs_lock  output  1  meaning arbitration lock to the locker control.
REQ-012 SHALL have port hs_data  output  DATA_W  meaning the granted payload, held stable while hs_req or hs_lock is high.
REQ-013 SHALL have port hs_ack  input  1  meaning acknowledge from the locker control (its ack_in); it is asynchronous to clk.
REQ-014 SHALL have port grant_id  output  1  meaning index of the client owning the current transaction.
REQ-015 SHALL have port err_timeout  output  1  meaning sticky watchdog error flag.

Function
REQ-016 SHALL use the state machine IDLE -> ASSERT -> WAIT_HI -> RELEASE -> WAIT_LO -> IDLE.
REQ-017 SHALL assert cliN_ready combinationally only in IDLE, and only for the arbitration winner; a transfer completes at the clk edge where valid and ready are both high.
REQ-018 SHALL, on that transfer edge, register the winner's data into hs_data, set grant_id to the winner and move to ASSERT.
REQ-019 SHALL arbitrate round-robin: with both clients valid, the client not granted last wins; after reset, client 0 has priority.
REQ-020 SHALL, in ASSERT, drive hs_lock=1 and hs_req=1, both registered and rising together one cycle after the transfer edge, then move to WAIT_HI.
REQ-021 SHALL sample hs_ack only through the SYNC_STAGES synchronizer (ack_s); stay in WAIT_HI until ack_s=1.
REQ-022 SHALL, in RELEASE, deassert hs_req and hs_lock in the same cycle, then move to WAIT_LO; hs_lock SHALL never be low while hs_req is high.
REQ-023 SHALL leave WAIT_LO for IDLE only when ack_s=0; the next transfer therefore cannot start before the return-to-zero phase completes.
REQ-024 SHALL ignore valid while not in IDLE; a client that drops valid before being granted loses no state.
REQ-025 SHALL keep an hs_ack glitch in IDLE or ASSERT without effect on state.

Reset
REQ-026 SHALL, while rst=1 at a clk edge, force: state IDLE, hs_req=0, hs_lock=0, hs_data=0, grant_id=0, priority to client 0, synchronizer flops=0, err_timeout=0, watchdog counter=0.
REQ-027 SHALL hold cli0_ready=0 and cli1_ready=0 while rst=1, regardless of valid.
REQ-028 SHALL, on reset in mid-transaction, drop hs_req and hs_lock on the next edge and resume in IDLE with no replay of the aborted word.

Configuration
REQ-029 SHALL, with ARB_TIMEOUT_EN defined, count cycles spent in WAIT_HI or WAIT_LO and reset the count on every state change.
REQ-030 SHALL, with ARB_TIMEOUT_EN defined, on reaching TIMEOUT_CYC set err_timeout=1 (sticky until rst), drop hs_req/hs_lock and go to IDLE.
REQ-031 SHALL, without ARB_TIMEOUT_EN, omit the counter, wait indefinitely in WAIT_HI/WAIT_LO and tie err_timeout to 0.

Verification
REQ-032 SHALL cover: cli0_valid=1, data 0xA5 -> cli0_ready=1 for 1 cycle; next cycle hs_req=hs_lock=1, hs_data=0xA5, grant_id=0; hs_ack=1 -> after 2 sync cycles plus 1, req/lock=0; hs_ack=0 -> IDLE.
REQ-033 SHALL cover: both valid continuously, data 0x11/0x22 -> grants alternate 0,1,0,1; hs_data sequence 0x11,0x22,0x11,0x22.
REQ-034 SHALL cover: hs_ack held high after RELEASE for 10 cycles -> no ready asserted for those 10 cycles; first ready 1 cycle after synchronized fall.
REQ-035 SHALL cover: rst=1 during WAIT_HI -> next edge hs_req=hs_lock=0, grant_id=0; after release with cli1 only valid, data 0x3C -> cli1 granted.
REQ-036 SHALL cover: with ARB_TIMEOUT_EN and TIMEOUT_CYC=16, hs_ack stuck at 0 -> after 16 cycles in WAIT_HI, err_timeout=1, hs_req=0, state IDLE; without the macro, hs_req stays 1 for 100 cycles.

Source files
------------

// File: rtl/sync_arb_frontend.sv
// Two-client round-robin arbiter feeding a four-phase req/ack handshake with a synchronized ack.
// Optional watchdog on the handshake wait states is enabled by defining ARB_TIMEOUT_EN.
module sync_arb_frontend #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cli0_valid,
  input  logic [DATA_W-1:0] cli0_data,
  output logic              cli0_ready,
  input  logic              cli1_valid,
  input  logic [DATA_W-1:0] cli1_data,
  output logic              cli1_ready,
  output logic              hs_req,
  output logic              hs_lock,
  output logic [DATA_W-1:0] hs_data,
  input  logic              hs_ack,
  output logic              grant_id,
  output logic              err_timeout
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, ASSERT, WAIT_HI, RELEASE, WAIT_LO} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   prio;
  logic                   win;
  logic                   xfer;
  logic                   req_nxt;

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // prio names the client that wins a tie: the one not granted last
  always_comb begin
    win = 1'b0;
    if (cli0_valid && cli1_valid) win = prio;
    else if (cli1_valid)          win = 1'b1;
    xfer       = (state == IDLE) && !rst && (cli0_valid || cli1_valid);
    cli0_ready = xfer && !win;
    cli1_ready = xfer && win;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_hit;
  logic             waiting;
  logic             err_q;

  assign waiting = (state == WAIT_HI) || (state == WAIT_LO);
`endif

  always_comb begin
    state_nxt = state;
`ifdef ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state)
      IDLE:    if (xfer) state_nxt = ASSERT;
      ASSERT:  state_nxt = WAIT_HI;
      WAIT_HI: if (ack_s) state_nxt = RELEASE;
      RELEASE: state_nxt = WAIT_LO;
      WAIT_LO: if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    // the watchdog fires only when the wait state would otherwise persist
    if (waiting && (state_nxt == state) && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
      state_nxt   = IDLE;
      timeout_hit = 1'b1;
    end
`endif
    req_nxt = (state_nxt == ASSERT) || (state_nxt == WAIT_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hs_req   <= 1'b0;
      hs_lock  <= 1'b0;
      hs_data  <= '0;
      grant_id <= 1'b0;
      prio     <= 1'b0;
      ack_sync <= '0;
    end else begin
      state    <= state_nxt;
      hs_req   <= req_nxt;
      hs_lock  <= req_nxt;
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], hs_ack};
      if (xfer) begin
        hs_data  <= win ? cli1_data : cli0_data;
        grant_id <= win;
        prio     <= ~win;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (timeout_hit) err_q <= 1'b1;
      if (!waiting || (state_nxt != state)) wd_cnt <= '0;
      else                                  wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
